sw_dispatch_ctrl: RTL and testbench

SW_DISPATCH_CTRL -- requirements
Module: sw_dispatch_ctrl

---
 rtl/sw_pkg.sv | 26 ++
 rtl/sw_sync_fifo.sv | 76 +++++++
 rtl/sw_dispatch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sw_dispatch_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared base encodings, FSM states and bias helper for the dispatch controller
// Contents: BASE_* 2-bit nucleotide codes, sw_state_t controller states,
//           sw_zero() biased-zero value for a given score width.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_G = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    localparam int CNT_WIDTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QLOAD,
        ST_READY,
        ST_STREAM,
        ST_GAP
    } sw_state_t;

    // Scores travel biased by half the range; this is the bias value.
    function automatic int sw_zero(input int score_width);
        return 1 << (score_width - 1);
    endfunction

endpackage

// File: rtl/sw_sync_fifo.sv
// rtl/sw_sync_fifo.sv - single-clock first-word-fall-through FIFO
// Ports: clk/rst (async active-low), wr_en/wr_data push, rd_en pop,
//        rd_data head word (valid when !empty), empty/full status.
// A push is accepted while full if a pop happens in the same cycle.
module sw_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_rd;
    logic             do_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_en && (count_q != '0);
    assign do_wr = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sw_dispatch_ctrl.sv
// rtl/sw_dispatch_ctrl.sv - dispatches database sequences to a systolic scoring module and returns tagged scores
// Ports: clk/rst (async active-low); q_load/q_data/q_len query load;
//        db_valid/db_ready/db_base/db_last/db_id base stream in;
//        sm_en/sm_data/sm_query/sm_counter scoring-module drive;
//        sm_vld/sm_result scoring-module result; res_valid/res_ready/res_id/res_score
//        result stream out; busy and sticky err status.
module sw_dispatch_ctrl
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH  = 12,
    parameter int LENGTH       = 48,
    parameter int ID_WIDTH     = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int ZERO         = sw_zero(SCORE_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_load,
    input  logic [2*LENGTH-1:0]    q_data,
    input  logic [6:0]             q_len,
    input  logic                   db_valid,
    output logic                   db_ready,
    input  logic [1:0]             db_base,
    input  logic                   db_last,
    input  logic [ID_WIDTH-1:0]    db_id,
    output logic                   sm_en,
    output logic [1:0]             sm_data,
    output logic [2*LENGTH-1:0]    sm_query,
    output logic [CNT_WIDTH-1:0]   sm_counter,
    input  logic                   sm_vld,
    input  logic [SCORE_WIDTH-1:0] sm_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_WIDTH-1:0]    res_id,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   busy,
    output logic                   err
);

    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int RES_W = ID_WIDTH + SCORE_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    sw_state_t              state_q, state_d;
    logic [2*LENGTH-1:0]    sm_query_q, sm_query_d;
    logic [6:0]             q_len_q, q_len_d;
    logic [INF_W-1:0]       inflight_q, inflight_d;
    logic                   sm_en_q, sm_en_d;
    logic [1:0]             sm_data_q, sm_data_d;
    logic [CNT_WIDTH-1:0]   sm_counter_q, sm_counter_d;
    logic                   err_q, err_d;

    logic                   db_hs;
    logic                   admit;
    logic                   res_hs;
    logic                   tag_pop;
    logic                   tag_empty, tag_full;
    logic                   res_empty, res_full;
    logic [ID_WIDTH-1:0]    tag_head;
    logic [RES_W-1:0]       res_head;
    logic [RES_W-1:0]       res_word;
    logic                   unused_ok;

    // Admission is throttled only at sequence start; once a sequence is
    // open every base is taken so the systolic array sees no bubbles.
    assign db_ready = ((state_q == ST_READY) && (inflight_q < INF_W'(MAX_INFLIGHT)))
                    || (state_q == ST_STREAM);
    assign db_hs    = db_valid && db_ready;
    assign admit    = db_hs && (state_q == ST_READY);
    assign res_hs   = res_valid && res_ready;
    // A result with no outstanding tag is a protocol error and is dropped.
    assign tag_pop  = sm_vld && !tag_empty;
    assign res_word = {tag_head, sm_result + SCORE_WIDTH'(ZERO)};

    always_comb begin
        state_d      = state_q;
        sm_query_d   = sm_query_q;
        q_len_d      = q_len_q;
        sm_data_d    = sm_data_q;
        sm_counter_d = sm_counter_q;
        inflight_d   = inflight_q;
        sm_en_d      = db_hs;
        err_d        = err_q || (sm_vld && tag_empty);

        case (state_q)
            ST_IDLE: begin
                if (q_load) begin
                    state_d    = ST_QLOAD;
                    sm_query_d = q_data;
                    q_len_d    = q_len;
                end
            end
            ST_QLOAD:  state_d = ST_READY;
            ST_READY: begin
                if (admit) begin
                    state_d = db_last ? ST_GAP : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (db_hs && db_last) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:    state_d = ST_READY;
            default:   state_d = ST_IDLE;
        endcase

        if (db_hs) begin
            sm_data_d = db_base;
        end

        if (admit) begin
            sm_counter_d = '0;
        end else if (db_hs && (sm_counter_q != CNT_MAX)) begin
            sm_counter_d = sm_counter_q + 1'b1;
        end

        if (admit && !res_hs) begin
            inflight_d = inflight_q + 1'b1;
        end else if (res_hs && !admit) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sm_query_q   <= '0;
            q_len_q      <= '0;
            inflight_q   <= '0;
            sm_en_q      <= 1'b0;
            sm_data_q    <= BASE_A;
            sm_counter_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sm_query_q   <= sm_query_d;
            q_len_q      <= q_len_d;
            inflight_q   <= inflight_d;
            sm_en_q      <= sm_en_d;
            sm_data_q    <= sm_data_d;
            sm_counter_q <= sm_counter_d;
            err_q        <= err_d;
        end
    end

    sw_sync_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (admit),
        .wr_data (db_id),
        .rd_en   (tag_pop),
        .rd_data (tag_head),
        .empty   (tag_empty),
        .full    (tag_full)
    );

    sw_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_pop),
        .wr_data (res_word),
        .rd_en   (res_hs),
        .rd_data (res_head),
        .empty   (res_empty),
        .full    (res_full)
    );

    // Query length is held for the scoring side but not consumed here; the
    // inflight limit already keeps both FIFOs from overflowing.
    assign unused_ok = ^{q_len_q, tag_full, res_full};

    assign sm_en      = sm_en_q;
    assign sm_data    = sm_data_q;
    assign sm_query   = sm_query_q;
    assign sm_counter = sm_counter_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE) || (inflight_q != '0);
    assign res_valid  = !res_empty;
    assign res_id     = res_head[RES_W-1:SCORE_WIDTH];
    assign res_score  = res_head[SCORE_WIDTH-1:0];

endmodule

// File: tb/tb_sw_dispatch_ctrl.sv
// tb/tb_sw_dispatch_ctrl.sv - directed scoreboard bench for sw_dispatch_ctrl
module tb_sw_dispatch_ctrl;

    localparam int SW   = 12;
    localparam int LEN  = 48;
    localparam int IDW  = 8;
    localparam int MAXI = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            q_load;
    logic [2*LEN-1:0] q_data;
    logic [6:0]      q_len;
    logic            db_valid;
    logic            db_ready;
    logic [1:0]      db_base;
    logic            db_last;
    logic [IDW-1:0]  db_id;
    logic            sm_en;
    logic [1:0]      sm_data;
    logic [2*LEN-1:0] sm_query;
    logic [11:0]     sm_counter;
    logic            sm_vld;
    logic [SW-1:0]   sm_result;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic [SW-1:0]   res_score;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic [IDW-1:0]    adm_q[$];
    logic [IDW+SW-1:0] sb_q[$];

    sw_dispatch_ctrl #(
        .SCORE_WIDTH  (SW),
        .LENGTH       (LEN),
        .ID_WIDTH     (IDW),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_load     (q_load),
        .q_data     (q_data),
        .q_len      (q_len),
        .db_valid   (db_valid),
        .db_ready   (db_ready),
        .db_base    (db_base),
        .db_last    (db_last),
        .db_id      (db_id),
        .sm_en      (sm_en),
        .sm_data    (sm_data),
        .sm_query   (sm_query),
        .sm_counter (sm_counter),
        .sm_vld     (sm_vld),
        .sm_result  (sm_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_score  (res_score),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (db_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        assert (db_ready === 1'b1) else begin
            errors++;
            $error("FAIL db_ready_timeout observed=%0b expected=1", db_ready);
        end
    endtask

    // Bases cycle A,G,T,C; db_id is garbage on non-first beats.
    task automatic send_seq(input logic [IDW-1:0] id, input int n, input bit chk_each);
        logic [1:0] b;
        for (int i = 0; i < n; i++) begin
            b        = 2'(i);
            db_valid = 1'b1;
            db_base  = b;
            db_last  = (i == n - 1);
            db_id    = (i == 0) ? id : 8'hEE;
            wait_ready();
            step();
            if (chk_each) begin
                chk("sm_en", 128'(sm_en), 128'd1);
                chk("sm_data", 128'(sm_data), 128'(b));
                chk("sm_counter", 128'(sm_counter), 128'(i));
            end
        end
        db_valid = 1'b0;
        db_last  = 1'b0;
        adm_q.push_back(id);
        chk("sm_counter_final", 128'(sm_counter), (n - 1 > 4095) ? 128'd4095 : 128'(n - 1));
        chk("gap_db_ready", 128'(db_ready), 128'd0);
    endtask

    task automatic sm_pulse(input logic [SW-1:0] raw, input logic [SW-1:0] exp_score);
        logic [IDW-1:0] tag;
        tag = (adm_q.size() != 0) ? adm_q.pop_front() : 8'h00;
        sb_q.push_back({tag, exp_score});
        sm_vld    = 1'b1;
        sm_result = raw;
        step();
        sm_vld    = 1'b0;
    endtask

    task automatic deliver();
        int n;
        logic [IDW+SW-1:0] e;
        n = 0;
        while (res_valid !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        checks++;
        assert (res_valid === 1'b1) else begin
            errors++;
            $error("FAIL res_valid_timeout observed=%0b expected=1", res_valid);
        end
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("res_id", 128'(res_id), 128'(e[IDW+SW-1:SW]));
            chk("res_score", 128'(res_score), 128'(e[SW-1:0]));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_db_ready"}, 128'(db_ready), 128'd0);
        chk({tag, "_sm_en"}, 128'(sm_en), 128'd0);
        chk({tag, "_sm_data"}, 128'(sm_data), 128'd0);
        chk({tag, "_sm_query"}, 128'(sm_query), 128'd0);
        chk({tag, "_sm_counter"}, 128'(sm_counter), 128'd0);
        chk({tag, "_res_valid"}, 128'(res_valid), 128'd0);
        chk({tag, "_res_id"}, 128'(res_id), 128'd0);
        chk({tag, "_res_score"}, 128'(res_score), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_err"}, 128'(err), 128'd0);
    endtask

    initial begin
        logic [2*LEN-1:0]  qpat;
        logic [IDW+SW-1:0] e;

        rst       = 1'b0;
        q_load    = 1'b0;
        q_data    = '0;
        q_len     = '0;
        db_valid  = 1'b0;
        db_base   = 2'b00;
        db_last   = 1'b0;
        db_id     = '0;
        sm_vld    = 1'b0;
        sm_result = '0;
        res_ready = 1'b0;

        // Reset state
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b1;
        step();
        chk("idle_db_ready", 128'(db_ready), 128'd0);

        // Query load: captured next cycle, READY two cycles after q_load
        qpat   = {$urandom, $urandom, $urandom};
        q_load = 1'b1;
        q_len  = 7'd47;
        q_data = qpat;
        step();
        q_load = 1'b0;
        q_data = ~qpat;
        chk("sm_query_load", 128'(sm_query), 128'(qpat));
        chk("qload_db_ready", 128'(db_ready), 128'd0);
        chk("qload_busy", 128'(busy), 128'd1);
        step();
        chk("ready_db_ready", 128'(db_ready), 128'd1);
        q_load = 1'b1;
        step();
        q_load = 1'b0;
        chk("q_load_ignored", 128'(sm_query), 128'(qpat));
        chk("q_load_ignored_ready", 128'(db_ready), 128'd1);

        // AGTC, id 5, then one GAP cycle
        send_seq(8'd5, 4, 1'b1);
        step();
        chk("gap_sm_en", 128'(sm_en), 128'd0);
        chk("after_gap_db_ready", 128'(db_ready), 128'd1);

        // Biased score -2048+37 unbiases to 37
        sm_pulse(12'h825, 12'd37);
        deliver();

        // Order across three sequences with boundary scores
        send_seq(8'd10, 2, 1'b0);
        send_seq(8'd11, 1, 1'b0);
        send_seq(8'd12, 3, 1'b0);
        sm_pulse(12'h000, 12'h800);
        sm_pulse(12'h7FF, 12'hFFF);
        sm_pulse(12'hFFF, 12'h7FF);
        deliver();
        deliver();
        deliver();
        chk("drained_res_valid", 128'(res_valid), 128'd0);

        // Inflight limit: four admitted, fifth blocked until one delivery
        for (int k = 0; k < 4; k++) begin
            send_seq(8'(20 + k), 1, 1'b0);
        end
        step();
        chk("full_db_ready", 128'(db_ready), 128'd0);
        for (int k = 1; k <= 4; k++) begin
            sm_pulse(12'h800 + 12'(k), 12'(k));
        end
        db_valid = 1'b1;
        db_base  = 2'b10;
        db_last  = 1'b1;
        db_id    = 8'd24;
        step();
        step();
        chk("stalled_db_ready", 128'(db_ready), 128'd0);
        chk("stalled_sm_en", 128'(sm_en), 128'd0);
        deliver();
        chk("reopen_db_ready", 128'(db_ready), 128'd1);
        step();
        db_valid = 1'b0;
        db_last  = 1'b0;
        adm_q.push_back(8'd24);
        chk("fifth_sm_en", 128'(sm_en), 128'd1);
        chk("fifth_sm_data", 128'(sm_data), 128'd2);

        // Result arrival and delivery in the same cycle
        e = sb_q.pop_front();
        chk("simul_res_id", 128'(res_id), 128'(e[IDW+SW-1:SW]));
        chk("simul_res_score", 128'(res_score), 128'(e[SW-1:0]));
        sb_q.push_back({adm_q.pop_front(), 12'd5});
        sm_vld    = 1'b1;
        sm_result = 12'h805;
        res_ready = 1'b1;
        step();
        sm_vld    = 1'b0;
        res_ready = 1'b0;
        deliver();
        deliver();
        deliver();
        chk("drained2_res_valid", 128'(res_valid), 128'd0);
        chk("drained2_db_ready", 128'(db_ready), 128'd1);
        chk("drained2_err", 128'(err), 128'd0);

        // Counter saturation on a long sequence
        send_seq(8'd30, 4100, 1'b0);
        sm_pulse(12'h800, 12'h000);
        deliver();

        // Result with no outstanding sequence sets sticky err
        step();
        sm_vld    = 1'b1;
        sm_result = 12'h003;
        step();
        sm_vld    = 1'b0;
        chk("orphan_err", 128'(err), 128'd1);
        chk("orphan_res_valid", 128'(res_valid), 128'd0);
        step();
        step();
        step();
        chk("err_sticky", 128'(err), 128'd1);

        // Asynchronous reset in the middle of a sequence
        db_valid = 1'b1;
        db_base  = 2'b00;
        db_last  = 1'b0;
        db_id    = 8'd40;
        wait_ready();
        step();
        db_base  = 2'b01;
        step();
        chk("pre_rst_sm_en", 128'(sm_en), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        db_valid = 1'b0;
        adm_q.delete();
        step();
        step();
        rst = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_res_valid", 128'(res_valid), 128'd0);
        end
        res_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
